// File: rtl/apb_request_node_np_if.sv
// Bus bundle between an APB master / crossbar fabric and the request node.
// The node itself uses the slave modport; the environment uses master.
interface apb_request_node_np_if #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_PORTS      = 4,
  parameter int REQ_FLIT_WIDTH = 8+ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8,
  parameter int RSP_FLIT_WIDTH = 2+DATA_WIDTH
);
  logic [ADDR_WIDTH-1:0]               paddr;
  logic [2:0]                          pprot;
  logic                                pnse;
  logic                                psel;
  logic                                penable;
  logic                                pwrite;
  logic [DATA_WIDTH-1:0]               pwdata;
  logic [DATA_WIDTH/8-1:0]             pstrb;
  logic                                pready;
  logic [DATA_WIDTH-1:0]               prdata;
  logic                                pslverr;
  logic [NUM_PORTS-1:0]                txreq_valid;
  logic [NUM_PORTS-1:0]                txreq_ready;
  logic [NUM_PORTS*REQ_FLIT_WIDTH-1:0] txreq_flit;
  logic [NUM_PORTS-1:0]                rxrsp_valid;
  logic [NUM_PORTS*RSP_FLIT_WIDTH-1:0] rxrsp_flit;
  logic [NUM_PORTS-1:0]                rxrsp_ready;
  logic                                rsp_drop;

  modport master (
    output paddr, pprot, pnse, psel,
    output penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr,
    input  txreq_valid, txreq_flit,
    output txreq_ready,
    output rxrsp_valid, rxrsp_flit,
    input  rxrsp_ready, rsp_drop
  );

  modport slave (
    input  paddr, pprot, pnse, psel,
    input  penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr,
    output txreq_valid, txreq_flit,
    input  txreq_ready,
    input  rxrsp_valid, rxrsp_flit,
    output rxrsp_ready, rsp_drop
  );
endinterface

// File: rtl/apb_request_node_np.sv
// APB request node: one APB access at a time, routed to a crossbar port,
// completed by the matching response flit, with timeout and stale flush.
module apb_request_node_np #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_PORTS      = 4,
  parameter int PORT_W         = $clog2(NUM_PORTS),
  parameter int SRC_ID         = 0,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int REQ_FLIT_WIDTH = 8+ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8,
  parameter int RSP_FLIT_WIDTH = 2+DATA_WIDTH
) (
  input logic                  pclk,
  input logic                  preset_n,
  apb_request_node_np_if.slave bus
);
  localparam int SW = DATA_WIDTH/8;
  localparam int CNT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES-1 : 0);
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [PORT_W:0] NP = (PORT_W+1)'(NUM_PORTS);
  localparam logic [2:0] SRC = 3'(SRC_ID);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    DONE
  } state_t;

  state_t                              state;
  logic [PORT_W-1:0]                   port_q;
  logic                                wr_q;
  logic [CNT_W-1:0]                    cnt;
  logic [NUM_PORTS-1:0]                stale;
  logic [NUM_PORTS-1:0]                stale_d;
  logic [NUM_PORTS-1:0]                drop;
  logic [NUM_PORTS-1:0]                req_v;
  logic [NUM_PORTS*REQ_FLIT_WIDTH-1:0] flit_q;
  logic                                pready_q;
  logic                                pslverr_q;
  logic [DATA_WIDTH-1:0]               prdata_q;
  logic                                drop_q;

  logic [PORT_W-1:0]         sel;
  logic                      setup;
  logic                      dec_err;
  logic                      hit;
  logic                      tmo;
  logic [REQ_FLIT_WIDTH-1:0] req_flit;
  logic [RSP_FLIT_WIDTH-1:0] rsp_flit;
  logic [1:0]                rsp_code;
  logic [DATA_WIDTH-1:0]     rsp_data;

  assign sel     = bus.paddr[ADDR_WIDTH-1 -: PORT_W];
  assign setup   = bus.psel && !bus.penable;
  assign dec_err = ({1'b0, sel} >= NP);

  // Write payload is masked off on reads so the flit carries zeros.
  assign req_flit = {
    bus.pwrite,
    bus.pprot,
    bus.pnse,
    SRC,
    bus.paddr,
    bus.pwdata & {DATA_WIDTH{bus.pwrite}},
    bus.pstrb & {SW{bus.pwrite}}
  };

  assign rsp_flit =
    bus.rxrsp_flit[int'(port_q)*RSP_FLIT_WIDTH +: RSP_FLIT_WIDTH];
  assign rsp_code = rsp_flit[RSP_FLIT_WIDTH-1 -: 2];
  assign rsp_data = rsp_flit[DATA_WIDTH-1:0];

  assign hit = (state == WAIT_RSP)
            && bus.rxrsp_valid[port_q]
            && !stale[port_q];

  assign tmo = TMO_EN
            && (state == WAIT_RSP)
            && !hit
            && (cnt == CNT_LAST);

  // Every valid response is sunk; only the awaited one is consumed.
  always_comb begin
    drop = bus.rxrsp_valid;
    if (hit) drop[port_q] = 1'b0;
  end

  always_comb begin
    stale_d = stale & ~bus.rxrsp_valid;
    if (tmo) stale_d[port_q] = 1'b1;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state     <= IDLE;
      port_q    <= '0;
      wr_q      <= 1'b0;
      cnt       <= '0;
      stale     <= '0;
      req_v     <= '0;
      flit_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= |drop;
      stale  <= stale_d;
      unique case (state)
        IDLE: begin
          if (setup) begin
            if (dec_err) begin
              state     <= DONE;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
              prdata_q  <= '0;
            end else begin
              state      <= REQ;
              port_q     <= sel;
              wr_q       <= bus.pwrite;
              req_v[sel] <= 1'b1;
              flit_q[int'(sel)*REQ_FLIT_WIDTH +: REQ_FLIT_WIDTH]
                <= req_flit;
            end
          end
        end
        REQ: begin
          if (bus.txreq_ready[port_q]) begin
            state <= WAIT_RSP;
            req_v <= '0;
            cnt   <= '0;
          end
        end
        WAIT_RSP: begin
          cnt <= cnt + 1'b1;
          if (hit) begin
            state     <= DONE;
            pready_q  <= 1'b1;
            pslverr_q <= (rsp_code != 2'b00);
            prdata_q  <= wr_q ? '0 : rsp_data;
          end else if (tmo) begin
            state     <= DONE;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            prdata_q  <= '0;
          end
        end
        DONE: begin
          state     <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pready      = pready_q;
  assign bus.pslverr     = pslverr_q;
  assign bus.prdata      = prdata_q;
  assign bus.txreq_valid = req_v;
  assign bus.txreq_flit  = flit_q;
  assign bus.rxrsp_ready = '1;
  assign bus.rsp_drop    = drop_q;
endmodule
